// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - control/result bundle for the gated frequency meter
//
// Purpose: groups the measurement request and result signals of freq_meter.
// Signals:
//   start  request to begin a measurement (single-cycle pulse)
//   cont   re-arm automatically after each window
//   busy   meter is inside a gate window
//   freq   latched edge count of the last completed window
//   ovf    latched with freq, edge count saturated
//   valid  one-cycle pulse when freq/ovf update
// Modports: master drives start/cont, slave (the meter) drives the results.
interface freq_meter_if #(
  parameter int CNT_W = 26
) ();
  logic             start;
  logic             cont;
  logic             busy;
  logic [CNT_W-1:0] freq;
  logic             ovf;
  logic             valid;

  modport master (
    output start,
    output cont,
    input  busy,
    input  freq,
    input  ovf,
    input  valid
  );

  modport slave (
    input  start,
    input  cont,
    output busy,
    output freq,
    output ovf,
    output valid
  );
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter measuring an asynchronous input
//
// Purpose: counts rising edges of sig_in over a window of GATE_CYCLES
// clock_40MHz cycles and reports the count; a 1 s gate yields Hz directly.
// Ports:
//   clock_40MHz  master clock, all logic on its rising edge
//   reset        synchronous, active-high
//   sig_in       asynchronous signal under measurement
//   bus          freq_meter_if slave: start, cont in; busy, freq, ovf, valid out
module freq_meter #(
  parameter int GATE_CYCLES = 40000000,
  parameter int CNT_W       = 26
) (
  input  logic       clock_40MHz,
  input  logic       reset,
  input  logic       sig_in,
  freq_meter_if.slave bus
);
  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state, state_n;
  logic [GATE_W-1:0] gate_cnt, gate_n;
  logic [CNT_W-1:0]  edge_cnt, cnt_n, cnt_inc;
  logic              sat, sat_n, sat_inc;
  logic [CNT_W-1:0]  freq_q, freq_n;
  logic              ovf_q, ovf_n;
  logic              valid_q, valid_n;
  logic              sync1, sync2, prev;
  logic              edge_pulse;

  always_ff @(posedge clock_40MHz) begin
    if (reset) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
    end else begin
      state    <= state_n;
      gate_cnt <= gate_n;
      edge_cnt <= cnt_n;
      sat      <= sat_n;
      freq_q   <= freq_n;
      ovf_q    <= ovf_n;
      valid_q  <= valid_n;
      sync1    <= sig_in;
      sync2    <= sync1;
      prev     <= sync2;
    end
  end

  always_comb begin
    edge_pulse = sync2 & ~prev;
    // Saturating count including this cycle's edge; sat marks a lost edge.
    cnt_inc = edge_cnt;
    sat_inc = sat;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) sat_inc = 1'b1;
      else                     cnt_inc = edge_cnt + 1'b1;
    end

    state_n = state;
    gate_n  = gate_cnt;
    cnt_n   = edge_cnt;
    sat_n   = sat;
    freq_n  = freq_q;
    ovf_n   = ovf_q;
    valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = MEASURE;
          gate_n  = '0;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end
      end
      MEASURE: begin
        if (gate_cnt == GATE_LAST) begin
          // Last gate cycle: its edge is included, and the next window (if
          // re-armed) starts on the very next cycle so no edge is lost.
          freq_n  = cnt_inc;
          ovf_n   = sat_inc;
          valid_n = 1'b1;
          gate_n  = '0;
          cnt_n   = '0;
          sat_n   = 1'b0;
          state_n = bus.cont ? MEASURE : IDLE;
        end else begin
          gate_n = gate_cnt + 1'b1;
          cnt_n  = cnt_inc;
          sat_n  = sat_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = (state == MEASURE);
  assign bus.freq  = freq_q;
  assign bus.ovf   = ovf_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
module tb_freq_meter;
  typedef struct {
    int freq;
    int ovf;
    int at;
    int busy;
  } exp_t;

  logic clock_40MHz = 1'b0;
  logic reset;
  logic sig_in;
  int   cyc = 0;
  int   per = 0;
  int   phase = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   sum_a = 0;
  int   base;
  exp_t qa[$];
  exp_t qb[$];

  freq_meter_if #(.CNT_W(26)) ifa ();
  freq_meter_if #(.CNT_W(3))  ifb ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(26)) dut_a (
    .clock_40MHz(clock_40MHz), .reset(reset), .sig_in(sig_in), .bus(ifa.slave)
  );
  freq_meter #(.GATE_CYCLES(100), .CNT_W(3)) dut_b (
    .clock_40MHz(clock_40MHz), .reset(reset), .sig_in(sig_in), .bus(ifb.slave)
  );

  always #5 clock_40MHz = ~clock_40MHz;
  always @(posedge clock_40MHz) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic exp_t mk(input int f, input int o, input int t, input int b);
    exp_t e;
    e.freq = f; e.ovf = o; e.at = t; e.busy = b;
    return e;
  endfunction

  // Monitors: every valid pulse is matched against the oldest expectation.
  always @(negedge clock_40MHz) begin
    if (ifa.valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_spurious_valid", 32'(ifa.valid), 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_freq", 32'(ifa.freq), e.freq);
        chk("a_ovf", 32'(ifa.ovf), e.ovf);
        chk("a_valid_time", cyc, e.at);
        chk("a_busy_at_valid", 32'(ifa.busy), e.busy);
        sum_a += 32'(ifa.freq);
      end
    end
  end

  always @(negedge clock_40MHz) begin
    if (ifb.valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_spurious_valid", 32'(ifb.valid), 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_freq", 32'(ifb.freq), e.freq);
        chk("b_ovf", 32'(ifb.ovf), e.ovf);
        chk("b_valid_time", cyc, e.at);
        chk("b_busy_at_valid", 32'(ifb.busy), e.busy);
      end
    end
  end

  // One stimulus cycle: advance to the falling edge and step the generator.
  task automatic tick();
    @(negedge clock_40MHz);
    if (per != 0) begin
      phase = (phase + 1) % per;
      sig_in = (phase < per / 2);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic go_a(input logic c);
    ifa.start = 1'b1;
    ifa.cont  = c;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic go_b(input logic c);
    ifb.start = 1'b1;
    ifb.cont  = c;
    tick();
    ifb.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sig_in = 1'b0;
    ifa.start = 1'b1;  // start during reset must be ignored
    ifa.cont = 1'b0;
    ifb.start = 1'b0;
    ifb.cont = 1'b0;
    ticks(3);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_freq", 32'(ifa.freq), 0);
    chk("rst_ovf", 32'(ifa.ovf), 0);
    chk("rst_valid", 32'(ifa.valid), 0);
    reset = 1'b0;
    ifa.start = 1'b0;
    tick();
    chk("rst_start_ignored_busy", 32'(ifa.busy), 0);

    // Single window, period 10 -> 10 edges
    per = 10;
    ticks(30);
    base = cyc;
    qa.push_back(mk(10, 0, base + 101, 0));
    go_a(1'b0);
    chk("busy_after_start", 32'(ifa.busy), 1);
    wait_until(base + 120);
    chk("idle_after_window", 32'(ifa.busy), 0);

    // Continuous, period 20 -> 5 per window, three windows back to back
    per = 20;
    ticks(30);
    sum_a = 0;
    base = cyc;
    qa.push_back(mk(5, 0, base + 101, 1));
    qa.push_back(mk(5, 0, base + 201, 1));
    qa.push_back(mk(5, 0, base + 301, 0));
    go_a(1'b1);
    wait_until(base + 250);
    ifa.cont = 1'b0;
    wait_until(base + 320);
    chk("cont_total_edges", sum_a, 15);

    // CNT_W=3 saturation: 25 edges -> 7/ovf, then a quiet window -> 0
    per = 4;
    ticks(20);
    base = cyc;
    qb.push_back(mk(7, 1, base + 101, 1));
    qb.push_back(mk(0, 0, base + 201, 0));
    go_b(1'b1);
    wait_until(base + 100);
    per = 0;
    sig_in = 1'b0;
    wait_until(base + 150);
    ifb.cont = 1'b0;
    wait_until(base + 220);

    // sig_in held high: no edges
    sig_in = 1'b1;
    ticks(10);
    base = cyc;
    qa.push_back(mk(0, 0, base + 101, 0));
    go_a(1'b0);
    wait_until(base + 110);
    sig_in = 1'b0;
    ticks(10);

    // single rise landing on gate cycle 99 -> counted
    base = cyc;
    qa.push_back(mk(1, 0, base + 101, 0));
    go_a(1'b0);
    wait_until(base + 98);
    sig_in = 1'b1;
    wait_until(base + 110);
    sig_in = 1'b0;
    ticks(10);

    // single rise landing on the first IDLE cycle -> not counted
    base = cyc;
    qa.push_back(mk(0, 0, base + 101, 0));
    go_a(1'b0);
    wait_until(base + 99);
    sig_in = 1'b1;
    wait_until(base + 110);
    chk("freq_after_late_edge", 32'(ifa.freq), 0);
    sig_in = 1'b0;
    ticks(10);

    // start pulsed mid-window is ignored
    per = 10;
    ticks(20);
    base = cyc;
    qa.push_back(mk(10, 0, base + 101, 0));
    go_a(1'b0);
    wait_until(base + 51);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("busy_mid_window", 32'(ifa.busy), 1);
    wait_until(base + 130);
    chk("freq_held", 32'(ifa.freq), 10);

    // reset at gate cycle 50 aborts the window
    base = cyc;
    go_a(1'b0);
    wait_until(base + 51);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(ifa.busy), 0);
    chk("mid_rst_freq", 32'(ifa.freq), 0);
    chk("mid_rst_valid", 32'(ifa.valid), 0);
    ticks(150);

    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
